sram_access_ctrl: RTL
=====================

// Module: sram_access_ctrl
// PURPOSE
//  Memory-side stage directly downstream of the instruction sequencer/decoder.
//  Accepts the sequencer's Mem_OE/Mem_WE requests plus MAR/MDR values and runs the
//  off-chip async SRAM bus with parameterised wait states.
//  Returns read data for the MDR and a one-cycle Done pulse, so the fetch/load/store
//  paths are gated on Done instead of hard-coded wait states.
// PARAMETERS
//  ADDR_W    20  SRAM address width; MAR (16b) is zero-extended.
//  DATA_W    16  data word width.
//  RD_WAIT   2   cycles OE_N held low before read data is captured (>=1).
//  WR_PULSE  2   cycles WE_N held low per write (>=1).
// PORTS
//  Clk          in   1       system clock
//  Reset        in   1       synchronous, active-low reset
//  Mem_OE       in   1       read request from sequencer (active-high, level)
//  Mem_WE       in   1       write request from sequencer (active-high, level)
//  MAR          in   16      access address
//  MDR          in   DATA_W  write data
//  Data_to_CPU  out  DATA_W  captured read data; valid from the Done cycle onward
//  Done         out  1       one-cycle completion pulse
//  Busy         out  1       high from request acceptance through the Done cycle
//  SRAM_ADDR    out  ADDR_W  registered SRAM address
//  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out 1 each  active-low strobes
//  SRAM_DQ_I    in   DATA_W  SRAM data in (top-level tristate)
//  SRAM_DQ_O    out  DATA_W  SRAM data out
//  SRAM_DQ_OE   out  1       drive enable for SRAM_DQ_O
//  Rd_Count, Wr_Count  out 16  access counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (Reset==0 at a Clk edge):
//   - state IDLE, armed=1
//   - all *_N outputs = 1, SRAM_DQ_OE = 0, Done = 0, Busy = 0
//   - Data_to_CPU, SRAM_ADDR, SRAM_DQ_O = 0
//   - Reset asserted mid-access aborts it; WE_N/OE_N are high on the next edge; no Done.
//  FSM states: IDLE, RD_WAIT, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
//  IDLE:
//   - a request is accepted when armed=1 and (Mem_WE | Mem_OE).
//   - on acceptance: latch {MAR, MDR} and clear armed.
//   - Mem_WE and Mem_OE high together: the write is taken; the read is ignored.
//  Read path: IDLE -> RD_WAIT (CE_N=OE_N=0 for RD_WAIT cycles) -> RD_CAP (capture
//   SRAM_DQ_I into Data_to_CPU) -> DONE.
//   - Done is high 2+RD_WAIT cycles after the acceptance edge.
//  Write path: IDLE -> WR_SETUP (CE_N=0, DQ_OE=1, addr/data stable, WE_N=1)
//   -> WR_PULSE (WE_N=0 for WR_PULSE cycles) -> WR_HOLD (WE_N=1, DQ_OE=1) -> DONE.
//   - Done is high 3+WR_PULSE cycles after acceptance.
//   - SRAM_DQ_OE is never high while SRAM_OE_N is low.
//  DONE: Done=1 for exactly one cycle, then IDLE.
//  Re-arm: armed is set only after a cycle with Mem_OE=Mem_WE=0. A request held
//   across several sequencer states causes exactly one access.
//  UB_N = LB_N = CE_N (word access only).
//  Busy = (state != IDLE). Request changes while Busy are ignored.
// CONFIGURATION
//  SRAM_STATS_EN defined:
//   - Rd_Count/Wr_Count increment once per completed read/write (at DONE).
//   - counts saturate at 16'hFFFF; reset to 0.
//  SRAM_STATS_EN undefined:
//   - no counter flops; Rd_Count = Wr_Count = 0 constantly.
// STRUCTURE
//  Package sram_ctrl_pkg: state enum sram_state_t, word_t typedef (DATA_W),
//   default RD_WAIT/WR_PULSE constants.
//  Sub-module sram_wait_cnt: loadable down-counter with a zero flag, shared by
//   RD_WAIT and WR_PULSE.
// TESTING
//  1 Reset=0 mid-WR_PULSE -> next edge: WE_N=1, DQ_OE=0, state IDLE, no Done pulse.
//  2 Read MAR=16'h0042, SRAM model returns 16'hBEEF, RD_WAIT=2 -> Done at cycle 4
//    after acceptance, Data_to_CPU=16'hBEEF, SRAM_ADDR=20'h00042.
//  3 Write MAR=16'h1234, MDR=16'hA5A5, WR_PULSE=2 -> WE_N low 2 cycles, DQ_O=A5A5
//    throughout, Done at cycle 5; a later read of 16'h1234 returns A5A5.
//  4 Mem_OE held high for 6 cycles -> exactly one read and one Done; after a
//    one-cycle low then high again -> second read.
//  5 Mem_OE and Mem_WE high together -> write performed, OE_N stays high all access.
//  6 With SRAM_STATS_EN: 3 reads + 2 writes -> Rd_Count=3, Wr_Count=2.
//    Without SRAM_STATS_EN: both counters read 0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and default timing for the async SRAM access controller.
package sram_ctrl_pkg;
    localparam int DEF_ADDR_W   = 20;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_RD_WAIT  = 2;
    localparam int DEF_WR_PULSE = 2;

    typedef logic [DEF_DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_CAP,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE
    } sram_state_t;
endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt: loadable down-counter with a zero flag, timing both read waits and write pulses.
module sram_wait_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = cnt == '0;
endmodule

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: sequencer-facing async SRAM controller with wait states and a Done pulse.
// Define SRAM_STATS_EN to build the saturating read/write access counters.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_WAIT  = DEF_RD_WAIT,
    parameter int WR_PULSE = DEF_WR_PULSE
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [15:0]       MAR,
    input  logic [DATA_W-1:0] MDR,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              Done,
    output logic              Busy,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    input  logic [DATA_W-1:0] SRAM_DQ_I,
    output logic [DATA_W-1:0] SRAM_DQ_O,
    output logic              SRAM_DQ_OE,
    output logic [15:0]       Rd_Count,
    output logic [15:0]       Wr_Count
);
    localparam int MAXW = RD_WAIT > WR_PULSE ? RD_WAIT : WR_PULSE;
    localparam int CW   = $clog2(MAXW + 1);

    sram_state_t state, next;
    logic armed, req, accept, load, zero, rd_ph, wr_ph;
    logic [CW-1:0] load_val;

    assign req    = Mem_OE | Mem_WE;
    assign accept = state == S_IDLE && armed && req;

    sram_wait_cnt #(.W(CW)) u_wait (
        .clk  (Clk),
        .rst_n(Reset),
        .load (load),
        .value(load_val),
        .zero (zero)
    );

    // The counter is loaded with N-1 so the wait state lasts exactly N cycles.
    always_comb begin
        next     = state;
        load     = 1'b0;
        load_val = CW'(RD_WAIT - 1);
        case (state)
            S_IDLE: begin
                next = accept ? (Mem_WE ? S_WR_SETUP : S_RD_WAIT) : S_IDLE;
                load = accept && !Mem_WE;
            end
            S_RD_WAIT:  next = zero ? S_RD_CAP : S_RD_WAIT;
            S_RD_CAP:   next = S_DONE;
            S_WR_SETUP: begin
                next     = S_WR_PULSE;
                load     = 1'b1;
                load_val = CW'(WR_PULSE - 1);
            end
            S_WR_PULSE: next = zero ? S_WR_HOLD : S_WR_PULSE;
            S_WR_HOLD:  next = S_DONE;
            default:    next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= S_IDLE;
            armed       <= 1'b1;
            SRAM_ADDR   <= '0;
            SRAM_DQ_O   <= '0;
            Data_to_CPU <= '0;
        end else begin
            state <= next;
            if (accept) begin
                armed     <= 1'b0;
                SRAM_ADDR <= ADDR_W'(MAR);
                SRAM_DQ_O <= MDR;
            end else if (!req)
                armed <= 1'b1;
            if (state == S_RD_CAP)
                Data_to_CPU <= SRAM_DQ_I;
        end
    end

    // OE_N stays low through the capture cycle so the data is still driven when sampled.
    assign rd_ph      = state == S_RD_WAIT || state == S_RD_CAP;
    assign wr_ph      = state == S_WR_SETUP || state == S_WR_PULSE || state == S_WR_HOLD;
    assign SRAM_CE_N  = !(rd_ph || wr_ph);
    assign SRAM_OE_N  = !rd_ph;
    assign SRAM_WE_N  = state != S_WR_PULSE;
    assign SRAM_UB_N  = SRAM_CE_N;
    assign SRAM_LB_N  = SRAM_CE_N;
    assign SRAM_DQ_OE = wr_ph;
    assign Done       = state == S_DONE;
    assign Busy       = state != S_IDLE;

`ifdef SRAM_STATS_EN
    logic        is_wr;
    logic [15:0] rd_cnt, wr_cnt;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            is_wr  <= 1'b0;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (accept)
                is_wr <= Mem_WE;
            if (state == S_DONE && is_wr && wr_cnt != 16'hFFFF)
                wr_cnt <= wr_cnt + 16'd1;
            if (state == S_DONE && !is_wr && rd_cnt != 16'hFFFF)
                rd_cnt <= rd_cnt + 16'd1;
        end
    end

    assign Rd_Count = rd_cnt;
    assign Wr_Count = wr_cnt;
`else
    assign Rd_Count = '0;
    assign Wr_Count = '0;
`endif
endmodule
